// File: rtl/rob_commit_pkg.sv
// Shared types for the ROB retire stage: commit FSM state, ROB head record
// and architectural register count.
package rob_commit_pkg;

    localparam int ARCH_REGS = 32;
    localparam int ROB_IDX_W = 6;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } commit_state_t;

    typedef struct packed {
        logic [4:0]           rd;
        logic [ROB_IDX_W-1:0] pd;
        logic                 regf_we;
        logic [63:0]          order;
    } rob_head_t;

endpackage

// File: rtl/rob_commit_rrat.sv
// Retirement RAT storage: identity mapping on reset, one write port, two
// combinational read ports (commit lookup and debug/flush).
module rrat_array #(
    parameter int PHYS_REG_BITS = 6,
    parameter int ARCH_REGS     = 32,
    parameter int AW            = $clog2(ARCH_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [PHYS_REG_BITS-1:0] wdata,
    input  logic [AW-1:0]            raddr0,
    output logic [PHYS_REG_BITS-1:0] rdata0,
    input  logic [AW-1:0]            raddr1,
    output logic [PHYS_REG_BITS-1:0] rdata1
);

    logic [PHYS_REG_BITS-1:0] mem [ARCH_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                mem[i] <= PHYS_REG_BITS'(i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the array as of the last edge; a same-cycle write is not bypassed.
    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/rob_commit.sv
// ROB retire stage: pops the completed head, frees the superseded phys reg,
// updates the RRAT and checks retirement order. COMMIT_PERF_EN adds perf counters.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int PHYS_REG_BITS = ROB_IDX_W,
    parameter int ARCH_REGS     = rob_commit_pkg::ARCH_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rob_head_valid,
    input  logic                     rob_head_done,
    input  logic [4:0]               rob_head_rd,
    input  logic [PHYS_REG_BITS-1:0] rob_head_pd,
    input  logic                     rob_head_regf_we,
    input  logic [63:0]              rob_head_order,
    input  logic                     free_list_full,
    output logic                     rob_dequeue,
    output logic                     fl_enqueue,
    output logic [PHYS_REG_BITS-1:0] fl_wdata,
    output logic                     commit_valid,
    output logic [63:0]              commit_order,
    output logic                     order_err,
`ifdef COMMIT_PERF_EN
    output logic [31:0]              commit_count,
    output logic [31:0]              stall_cycles,
`endif
    input  logic [4:0]               rrat_rd_idx,
    output logic [PHYS_REG_BITS-1:0] rrat_rd_data
);

    rob_head_t                head;
    commit_state_t            state;
    logic [63:0]              expected_order;
    logic [PHYS_REG_BITS-1:0] old_pd;
    logic                     head_ready;
    logic                     fire;
    logic                     rrat_we;

    assign head = '{rd: rob_head_rd, pd: rob_head_pd,
                    regf_we: rob_head_regf_we, order: rob_head_order};

    assign head_ready  = rob_head_valid & rob_head_done;
    assign fire        = head_ready & ~free_list_full & (state == RUN);
    assign rob_dequeue = fire;
    // x0 is never architecturally mapped, so it never takes an RRAT write.
    assign rrat_we     = fire & head.regf_we & (head.rd != 5'd0);

    rrat_array #(
        .PHYS_REG_BITS(PHYS_REG_BITS),
        .ARCH_REGS    (ARCH_REGS)
    ) u_rrat (
        .clk   (clk),
        .rst   (rst),
        .we    (rrat_we),
        .waddr (head.rd),
        .wdata (head.pd),
        .raddr0(head.rd),
        .rdata0(old_pd),
        .raddr1(rrat_rd_idx),
        .rdata1(rrat_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            expected_order <= '0;
            fl_enqueue     <= 1'b0;
            fl_wdata       <= '0;
            commit_valid   <= 1'b0;
            commit_order   <= '0;
            order_err      <= 1'b0;
        end else begin
            fl_enqueue   <= fire & head.regf_we;
            commit_valid <= fire;
            if (fire) begin
                commit_order   <= head.order;
                expected_order <= expected_order + 64'd1;
                if (head.order != expected_order) begin
                    order_err <= 1'b1;
                end
                if (head.regf_we) begin
                    fl_wdata <= (head.rd == 5'd0) ? head.pd : old_pd;
                end
            end
            case (state)
                RUN:   if (head_ready & free_list_full) state <= STALL;
                STALL: if (!free_list_full) state <= RUN;
            endcase
        end
    end

`ifdef COMMIT_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_count <= '0;
            stall_cycles <= '0;
        end else begin
            if (fire) begin
                commit_count <= sat_inc(commit_count);
            end
            if (state == STALL) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end
`endif

endmodule
